// File: rtl/time_set_ctrl_if.sv
// Button/clock-counter bundle for the binary-clock set-time controller.
// The master drives buttons and live time; the slave (controller) drives the load/blank side.
interface time_set_ctrl_if;
   logic       btn_mode;
   logic       btn_adj;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [4:0] set_hours;
   logic [5:0] set_minutes;
   logic       load;
   logic       setting;
   logic       blank_hours;
   logic       blank_minutes;

   modport master (
      output btn_mode, btn_adj, cur_hours, cur_minutes,
      input  set_hours, set_minutes, load, setting, blank_hours, blank_minutes
   );

   modport slave (
      input  btn_mode, btn_adj, cur_hours, cur_minutes,
      output set_hours, set_minutes, load, setting, blank_hours, blank_minutes
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Set-time controller: debounces MODE/ADJ and edits hours/minutes shadows for the clock counters.
// Optional feature macro: AUTO_REPEAT_EN (held ADJ auto-increments after a delay).
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int BLINK_CYCLES    = 50,
   parameter int TIMEOUT_CYCLES  = 3000
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_RATE     = 10
`endif
) (
   input  logic               clk,
   input  logic               rst,
   time_set_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } state_t;

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BKW = $clog2(BLINK_CYCLES + 1);
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

   // Bit 0 = MODE, bit 1 = ADJ throughout the input path.
   logic [1:0]          sync1_q, sync1_d;
   logic [1:0]          sync2_q, sync2_d;
   logic [1:0]          level_q, level_d;
   logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]          press_q, press_d;

   state_t              state_q, state_d;
   logic [4:0]          hours_q, hours_d;
   logic [5:0]          minutes_q, minutes_d;
   logic                load_q, load_d;
   logic                setting_q, setting_d;
   logic                blank_hours_q, blank_hours_d;
   logic                blank_minutes_q, blank_minutes_d;
   logic [BKW-1:0]      blink_cnt_q, blink_cnt_d;
   logic                blink_q, blink_d;
   logic [TOW-1:0]      to_cnt_q, to_cnt_d;

   logic                mode_p_s;
   logic                adj_p_s;
   logic                adj_event_s;
   logic                rep_fire_s;

   // Two-flop synchronizer feeding the debounce counters.
   always_comb begin
      sync1_d = {bus.btn_adj, bus.btn_mode};
      sync2_d = sync1_q;
   end

   // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; rising acceptance pulses.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      press_d  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i]  = sync2_q[i];
               db_cnt_d[i] = {DBW{1'b0}};
               press_d[i]  = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + {{(DBW-1){1'b0}}, 1'b1};
            end
         end else begin
            db_cnt_d[i] = {DBW{1'b0}};
         end
      end
   end

   // Mode pulse has priority: a simultaneous adj pulse is dropped.
   always_comb begin
      mode_p_s    = press_q[0];
      adj_p_s     = press_q[1] & ~press_q[0];
      adj_event_s = adj_p_s | rep_fire_s;
   end

`ifdef AUTO_REPEAT_EN
   localparam int RPW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   logic           rep_active_q, rep_active_d;
   logic           rep_first_q, rep_first_d;
   logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
   logic           rep_hold_s;

   // Auto-repeat: first extra step after REPEAT_DELAY, then every REPEAT_RATE while ADJ held.
   always_comb begin
      rep_active_d = rep_active_q;
      rep_first_d  = rep_first_q;
      rep_cnt_d    = rep_cnt_q;
      rep_fire_s   = 1'b0;
      rep_hold_s   = rep_active_q & level_q[1] & (state_q != RUN) & ~mode_p_s;
      if (rep_hold_s) begin
         if (rep_first_q) begin
            rep_fire_s = (rep_cnt_q == RPW'(REPEAT_DELAY - 1));
         end else begin
            rep_fire_s = (rep_cnt_q == RPW'(REPEAT_RATE - 1));
         end
      end else begin
         rep_fire_s = 1'b0;
      end

      if ((state_q != RUN) && adj_p_s) begin
         rep_active_d = 1'b1;
         rep_first_d  = 1'b1;
         rep_cnt_d    = {RPW{1'b0}};
      end else if (rep_fire_s) begin
         rep_first_d  = 1'b0;
         rep_cnt_d    = {RPW{1'b0}};
      end else if (rep_hold_s) begin
         rep_cnt_d    = rep_cnt_q + {{(RPW-1){1'b0}}, 1'b1};
      end else begin
         rep_active_d = 1'b0;
         rep_first_d  = 1'b0;
         rep_cnt_d    = {RPW{1'b0}};
      end
   end

   // Auto-repeat state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_active_q <= 1'b0;
         rep_first_q  <= 1'b0;
         rep_cnt_q    <= {RPW{1'b0}};
      end else begin
         rep_active_q <= rep_active_d;
         rep_first_q  <= rep_first_d;
         rep_cnt_q    <= rep_cnt_d;
      end
   end
`else
   // Without auto-repeat only debounced ADJ presses increment.
   always_comb begin
      rep_fire_s = 1'b0;
   end
`endif

   // Set-time FSM with timeout, blink phase and the registered load/blank outputs.
   always_comb begin
      state_d     = state_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      load_d      = 1'b0;
      to_cnt_d    = to_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;

      case (state_q)
         RUN: begin
            to_cnt_d    = {TOW{1'b0}};
            blink_cnt_d = {BKW{1'b0}};
            blink_d     = 1'b0;
            if (mode_p_s) begin
               hours_d   = bus.cur_hours;
               minutes_d = bus.cur_minutes;
               state_d   = SET_H;
            end else begin
               state_d   = RUN;
            end
         end
         SET_H, SET_M: begin
            if (mode_p_s || adj_event_s) begin
               // Any accepted press (or repeat step) restarts timeout and makes the field visible.
               to_cnt_d    = {TOW{1'b0}};
               blink_cnt_d = {BKW{1'b0}};
               blink_d     = 1'b0;
               if (mode_p_s) begin
                  state_d = (state_q == SET_H) ? SET_M : RUN;
                  load_d  = (state_q == SET_M);
               end else if (state_q == SET_H) begin
                  hours_d = (hours_q >= 5'd23) ? 5'd0 : hours_q + 5'd1;
               end else begin
                  minutes_d = (minutes_q >= 6'd59) ? 6'd0 : minutes_q + 6'd1;
               end
            end else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
               state_d     = RUN;
               to_cnt_d    = {TOW{1'b0}};
               blink_cnt_d = {BKW{1'b0}};
               blink_d     = 1'b0;
            end else begin
               to_cnt_d = to_cnt_q + {{(TOW-1){1'b0}}, 1'b1};
               if (blink_cnt_q == BKW'(BLINK_CYCLES - 1)) begin
                  blink_cnt_d = {BKW{1'b0}};
                  blink_d     = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + {{(BKW-1){1'b0}}, 1'b1};
               end
            end
         end
         default: begin
            state_d     = RUN;
            to_cnt_d    = {TOW{1'b0}};
            blink_cnt_d = {BKW{1'b0}};
            blink_d     = 1'b0;
         end
      endcase

      setting_d       = (state_d != RUN);
      blank_hours_d   = (state_d == SET_H) & blink_d;
      blank_minutes_d = (state_d == SET_M) & blink_d;
   end

   // All state and outputs are registered; reset abandons any edit in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q         <= 2'b00;
         sync2_q         <= 2'b00;
         level_q         <= 2'b00;
         db_cnt_q        <= {(2*DBW){1'b0}};
         press_q         <= 2'b00;
         state_q         <= RUN;
         hours_q         <= 5'd0;
         minutes_q       <= 6'd0;
         load_q          <= 1'b0;
         setting_q       <= 1'b0;
         blank_hours_q   <= 1'b0;
         blank_minutes_q <= 1'b0;
         blink_cnt_q     <= {BKW{1'b0}};
         blink_q         <= 1'b0;
         to_cnt_q        <= {TOW{1'b0}};
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         level_q         <= level_d;
         db_cnt_q        <= db_cnt_d;
         press_q         <= press_d;
         state_q         <= state_d;
         hours_q         <= hours_d;
         minutes_q       <= minutes_d;
         load_q          <= load_d;
         setting_q       <= setting_d;
         blank_hours_q   <= blank_hours_d;
         blank_minutes_q <= blank_minutes_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_q         <= blink_d;
         to_cnt_q        <= to_cnt_d;
      end
   end

   assign bus.set_hours     = hours_q;
   assign bus.set_minutes   = minutes_q;
   assign bus.load          = load_q;
   assign bus.setting       = setting_q;
   assign bus.blank_hours   = blank_hours_q;
   assign bus.blank_minutes = blank_minutes_q;

endmodule
